// File: rtl/mult_sequencer_if.sv
// Multiplier request/response bundle: operands and start in, status and product out.
interface mult_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             signed_op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  // Processor side issues the operation and watches busy/done.
  modport master (
    output start, signed_op, a, b,
    input  busy, done, hi, lo
  );

  // Multiplier side consumes the request and drives the result.
  modport slave (
    input  start, signed_op, a, b,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mult_sequencer.sv
// Sequential shift-add multiplier for MIPS mult/multu.
// Processes one multiplier bit per clock, so a result takes WIDTH cycles.
// Signed operands are reduced to magnitudes, and the sign is fixed up on the final add.
module mult_sequencer #(
  parameter int WIDTH = 32
) (
  input logic             clk,
  input logic             reset,
  mult_sequencer_if.slave bus
);
  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t             state;
  logic [CW-1:0]      count;
  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic               signed_reg;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   hi_reg;
  logic [WIDTH-1:0]   lo_reg;

  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic               negate;
  logic [2*WIDTH-1:0] addend;
  logic [2*WIDTH-1:0] sum;
  logic [2*WIDTH-1:0] product;

  // Magnitudes, partial-product step and final sign fix-up.
  // The most negative value maps to 2^(WIDTH-1), which still fits unsigned.
  always_comb begin
    mag_a   = (signed_reg && a_reg[WIDTH-1]) ? (-a_reg) : a_reg;
    mag_b   = (signed_reg && b_reg[WIDTH-1]) ? (-b_reg) : b_reg;
    negate  = signed_reg && (a_reg[WIDTH-1] ^ b_reg[WIDTH-1]);
    addend  = mag_b[count] ? ({{WIDTH{1'b0}}, mag_a} << count) : '0;
    sum     = acc + addend;
    product = negate ? (-sum) : sum;
  end

  // Control FSM and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      count      <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      signed_reg <= 1'b0;
      acc        <= '0;
      hi_reg     <= '0;
      lo_reg     <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            a_reg      <= bus.a;
            b_reg      <= bus.b;
            signed_reg <= bus.signed_op;
            count      <= '0;
            acc        <= '0;
            state      <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          acc   <= sum;
          count <= count + 1'b1;
          if (count == LAST) begin
            hi_reg <= product[2*WIDTH-1:WIDTH];
            lo_reg <= product[WIDTH-1:0];
            state  <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);
  assign bus.hi   = hi_reg;
  assign bus.lo   = lo_reg;
endmodule

// File: tb/tb_mult_sequencer.sv
// Directed bench for mult_sequencer: latency, products, start handling and reset abort.
module tb_mult_sequencer;
  logic clk;
  logic reset;
  int   total;
  int   bad;
  logic [31:0] prev_hi;
  logic [31:0] prev_lo;

  typedef struct {
    int          lat;
    int          busy_cnt;
    bit          changed;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        done_after;
    logic        busy_after;
  } obs_t;

  mult_sequencer_if #(.WIDTH(32)) bus ();

  mult_sequencer #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global time bound so the bench can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Drive a start pulse that is sampled by exactly one rising edge (edge N).
  task automatic launch(input logic sgn, input logic [31:0] av, input logic [31:0] bv);
    @(negedge clk);
    bus.start     = 1'b1;
    bus.signed_op = sgn;
    bus.a         = av;
    bus.b         = bv;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Observe from just after edge N until done, then one more edge; no judging here.
  task automatic run_op(input logic sgn, input logic [31:0] av, input logic [31:0] bv,
                        output obs_t o);
    int i;
    launch(sgn, av, bv);
    o.lat      = -1;
    o.busy_cnt = bus.busy ? 1 : 0;
    o.changed  = (bus.hi !== prev_hi) || (bus.lo !== prev_lo);
    i = 0;
    while (o.lat < 0 && i < 100) begin
      @(posedge clk);
      #1;
      i++;
      if (bus.done) begin
        o.lat = i;
      end else begin
        if (bus.busy) o.busy_cnt++;
        if ((bus.hi !== prev_hi) || (bus.lo !== prev_lo)) o.changed = 1'b1;
      end
    end
    o.hi = bus.hi;
    o.lo = bus.lo;
    @(posedge clk);
    #1;
    o.done_after = bus.done;
    o.busy_after = bus.busy;
  endtask

  task automatic test_reset();
    reset         = 1'b0;
    bus.start     = 1'b0;
    bus.signed_op = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    #2;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b want=0", bus.busy); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("[TB] FAIL reset_done got=%b want=0", bus.done); end
    total++; if (bus.hi !== 32'h0) begin bad++; $display("[TB] FAIL reset_hi got=%h want=0", bus.hi); end
    total++; if (bus.lo !== 32'h0) begin bad++; $display("[TB] FAIL reset_lo got=%h want=0", bus.lo); end
    bus.start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_hold_busy got=%b want=0", bus.busy); end
    bus.start = 1'b0;
    @(negedge clk);
    reset   = 1'b1;
    prev_hi = 32'h0;
    prev_lo = 32'h0;
  endtask

  task automatic test_unsigned();
    obs_t o;
    run_op(1'b0, 32'd3, 32'd5, o);
    total++; if (o.lat != 32) begin bad++; $display("[TB] FAIL u3x5_latency got=%0d want=32", o.lat); end
    total++; if (o.busy_cnt != 32) begin bad++; $display("[TB] FAIL u3x5_busy_cycles got=%0d want=32", o.busy_cnt); end
    total++; if (o.changed) begin bad++; $display("[TB] FAIL u3x5_hold got=changed want=held"); end
    total++; if (o.hi !== 32'h0) begin bad++; $display("[TB] FAIL u3x5_hi got=%h want=00000000", o.hi); end
    total++; if (o.lo !== 32'hF) begin bad++; $display("[TB] FAIL u3x5_lo got=%h want=0000000f", o.lo); end
    total++; if (o.done_after !== 1'b0) begin bad++; $display("[TB] FAIL u3x5_done_pulse got=%b want=0", o.done_after); end
    total++; if (o.busy_after !== 1'b0) begin bad++; $display("[TB] FAIL u3x5_idle_busy got=%b want=0", o.busy_after); end
    prev_hi = 32'h0; prev_lo = 32'hF;
    run_op(1'b0, 32'h8000_0000, 32'd2, o);
    total++; if (o.changed) begin bad++; $display("[TB] FAIL u_big_hold got=changed want=held"); end
    total++; if (o.hi !== 32'h1) begin bad++; $display("[TB] FAIL u_big_hi got=%h want=00000001", o.hi); end
    total++; if (o.lo !== 32'h0) begin bad++; $display("[TB] FAIL u_big_lo got=%h want=00000000", o.lo); end
    prev_hi = 32'h1; prev_lo = 32'h0;
  endtask

  task automatic test_signed();
    obs_t o;
    run_op(1'b1, 32'hFFFF_FFFF, 32'h2, o);
    total++; if (o.lat != 32) begin bad++; $display("[TB] FAIL sm1x2_latency got=%0d want=32", o.lat); end
    total++; if (o.hi !== 32'hFFFF_FFFF) begin bad++; $display("[TB] FAIL sm1x2_hi got=%h want=ffffffff", o.hi); end
    total++; if (o.lo !== 32'hFFFF_FFFE) begin bad++; $display("[TB] FAIL sm1x2_lo got=%h want=fffffffe", o.lo); end
    prev_hi = 32'hFFFF_FFFF; prev_lo = 32'hFFFF_FFFE;
    run_op(1'b1, 32'hFFFF_FFFD, 32'd5, o);
    total++; if (o.hi !== 32'hFFFF_FFFF) begin bad++; $display("[TB] FAIL sm3x5_hi got=%h want=ffffffff", o.hi); end
    total++; if (o.lo !== 32'hFFFF_FFF1) begin bad++; $display("[TB] FAIL sm3x5_lo got=%h want=fffffff1", o.lo); end
    prev_hi = 32'hFFFF_FFFF; prev_lo = 32'hFFFF_FFF1;
    run_op(1'b1, 32'd7, 32'hFFFF_FFFA, o);
    total++; if (o.hi !== 32'hFFFF_FFFF) begin bad++; $display("[TB] FAIL s7xm6_hi got=%h want=ffffffff", o.hi); end
    total++; if (o.lo !== 32'hFFFF_FFD6) begin bad++; $display("[TB] FAIL s7xm6_lo got=%h want=ffffffd6", o.lo); end
    prev_hi = 32'hFFFF_FFFF; prev_lo = 32'hFFFF_FFD6;
  endtask

  task automatic test_extremes();
    obs_t o;
    run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, o);
    total++; if (o.hi !== 32'hFFFF_FFFE) begin bad++; $display("[TB] FAIL umax_hi got=%h want=fffffffe", o.hi); end
    total++; if (o.lo !== 32'h0000_0001) begin bad++; $display("[TB] FAIL umax_lo got=%h want=00000001", o.lo); end
    prev_hi = 32'hFFFF_FFFE; prev_lo = 32'h1;
    run_op(1'b1, 32'h8000_0000, 32'h8000_0000, o);
    total++; if (o.hi !== 32'h4000_0000) begin bad++; $display("[TB] FAIL smin_hi got=%h want=40000000", o.hi); end
    total++; if (o.lo !== 32'h0) begin bad++; $display("[TB] FAIL smin_lo got=%h want=00000000", o.lo); end
    prev_hi = 32'h4000_0000; prev_lo = 32'h0;
  endtask

  task automatic test_start_ignored();
    int cycles;
    int extra_done;
    launch(1'b0, 32'd12, 32'd11);
    repeat (4) @(posedge clk);
    #1;
    bus.start     = 1'b1;
    bus.signed_op = 1'b1;
    bus.a         = 32'd100;
    bus.b         = 32'hFFFF_FF00;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    cycles = 5;
    while (!bus.done && cycles < 100) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    total++; if (cycles != 32) begin bad++; $display("[TB] FAIL ign_latency got=%0d want=32", cycles); end
    total++; if (bus.hi !== 32'h0) begin bad++; $display("[TB] FAIL ign_hi got=%h want=00000000", bus.hi); end
    total++; if (bus.lo !== 32'h84) begin bad++; $display("[TB] FAIL ign_lo got=%h want=00000084", bus.lo); end
    extra_done = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.done) extra_done++;
    end
    total++; if (extra_done != 0) begin bad++; $display("[TB] FAIL ign_second_done got=%0d want=0", extra_done); end
    prev_hi = 32'h0; prev_lo = 32'h84;
  endtask

  task automatic test_back_to_back();
    obs_t o;
    launch(1'b0, 32'd9, 32'd9);
    repeat (31) @(posedge clk);
    #1;
    bus.start     = 1'b1;
    bus.signed_op = 1'b0;
    bus.a         = 32'd7;
    bus.b         = 32'd6;
    @(posedge clk);
    #1;
    total++; if (bus.done !== 1'b1) begin bad++; $display("[TB] FAIL b2b_first_done got=%b want=1", bus.done); end
    total++; if (bus.lo !== 32'h51) begin bad++; $display("[TB] FAIL b2b_first_lo got=%h want=00000051", bus.lo); end
    @(posedge clk);
    #1;
    total++; if (bus.done !== 1'b0) begin bad++; $display("[TB] FAIL b2b_pulse_width got=%b want=0", bus.done); end
    total++; if (bus.busy !== 1'b1) begin bad++; $display("[TB] FAIL b2b_busy_rise got=%b want=1", bus.busy); end
    total++; if (bus.lo !== 32'h51) begin bad++; $display("[TB] FAIL b2b_hold_lo got=%h want=00000051", bus.lo); end
    bus.start = 1'b0;
    o.lat = -1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk);
      #1;
      if (bus.done && o.lat < 0) o.lat = i;
      if (o.lat >= 0) i = 101;
    end
    total++; if (o.lat != 32) begin bad++; $display("[TB] FAIL b2b_second_latency got=%0d want=32", o.lat); end
    total++; if (bus.hi !== 32'h0) begin bad++; $display("[TB] FAIL b2b_second_hi got=%h want=00000000", bus.hi); end
    total++; if (bus.lo !== 32'h2A) begin bad++; $display("[TB] FAIL b2b_second_lo got=%h want=0000002a", bus.lo); end
    @(posedge clk);
    #1;
    prev_hi = 32'h0; prev_lo = 32'h2A;
  endtask

  task automatic test_reset_mid_run();
    int done_seen;
    launch(1'b0, 32'd3, 32'd5);
    repeat (10) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL abort_busy got=%b want=0", bus.busy); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("[TB] FAIL abort_done got=%b want=0", bus.done); end
    total++; if (bus.hi !== 32'h0) begin bad++; $display("[TB] FAIL abort_hi got=%h want=00000000", bus.hi); end
    total++; if (bus.lo !== 32'h0) begin bad++; $display("[TB] FAIL abort_lo got=%h want=00000000", bus.lo); end
    @(negedge clk);
    reset = 1'b1;
    done_seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.done) done_seen++;
    end
    total++; if (done_seen != 0) begin bad++; $display("[TB] FAIL abort_late_done got=%0d want=0", done_seen); end
    total++; if (bus.lo !== 32'h0) begin bad++; $display("[TB] FAIL abort_late_lo got=%h want=00000000", bus.lo); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_unsigned();
    test_signed();
    test_extremes();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mult_sequencer.md
MULT_SEQUENCER -- requirements
Module: mult_sequencer

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 32, operand width in bits; only 32 is required to be supported.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = reset asserted).
REQ-004 The block SHALL have port start, input, 1 bit: request to begin a multiply; sampled on clk rising edge.
REQ-005 The block SHALL have port signed_op, input, 1 bit: 1 = signed (MIPS mult), 0 = unsigned (MIPS multu); sampled with start.
REQ-006 The block SHALL have port a, input, 32 bits: multiplicand; sampled with start.
REQ-007 The block SHALL have port b, input, 32 bits: multiplier; sampled with start.
REQ-008 The block SHALL have port busy, output, 1 bit: high while a multiply is in progress; the processor stalls on it.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse; hi/lo hold a new result.
REQ-010 The block SHALL have port hi, output, 32 bits: upper half of the 64-bit product (mfhi source).
REQ-011 The block SHALL have port lo, output, 32 bits: lower half of the 64-bit product (mflo source).

Function
REQ-012 The block SHALL implement three states: IDLE, RUN and DONE.
REQ-013 In IDLE or DONE, a rising edge with start=1 (edge N) SHALL latch a, b and signed_op, clear the bit counter to 0, clear the partial product and enter RUN.
REQ-014 In IDLE or DONE, a rising edge with start=0 SHALL go to (or stay in) IDLE.
REQ-015 DONE SHALL last exactly one cycle unless start=1 at its closing edge, per REQ-013.
REQ-016 RUN SHALL process one multiplier bit per edge (shift-add), incrementing a 5-bit counter.
REQ-017 The RUN edge with counter=31 SHALL finish the product, write hi/lo and enter DONE, so DONE is entered at edge N+32.
REQ-018 In RUN, start SHALL be ignored; the operands and signed_op latched in RUN SHALL NOT change.
REQ-019 busy SHALL be 1 exactly when state=RUN, and done SHALL be 1 exactly when state=DONE; both are registered-state decodes with no combinational path from start.
REQ-020 For unsigned operation, the block SHALL compute the full 64-bit product {hi,lo} = a*b.
REQ-021 For signed operation, the block SHALL multiply the magnitudes of the two's-complement operands, then negate the 64-bit result when the operand signs differ.
REQ-022 Magnitude of 0x80000000 SHALL be 2^31 (fits in 32 unsigned bits, no overflow).
REQ-023 hi/lo SHALL change only on entry to DONE and otherwise hold the last result, including during RUN and IDLE.
REQ-024 Back-to-back operation SHALL be supported: start=1 while done=1 begins the next multiply, and the pulse from the first multiply stays exactly one cycle.

Reset
REQ-025 While reset=0, regardless of clk, the block SHALL set state=IDLE, counter=0, busy=0, done=0, hi=0, lo=0 and clear the latched operands.
REQ-026 When reset deasserts, the block SHALL wait in IDLE; the first start SHALL be accepted on the first rising edge with reset=1 and start=1.
REQ-027 Reset asserted during RUN or DONE SHALL abort the operation immediately, and the aborted multiply SHALL NOT later produce done or update hi/lo.

Verification
REQ-028 The bench SHALL apply unsigned 3 x 5 and check: busy=1 for 32 cycles, then done=1 for one cycle with hi=0x00000000, lo=0x0000000F.
REQ-029 The bench SHALL apply signed 0xFFFFFFFF x 0x00000002 and check hi=0xFFFFFFFF, lo=0xFFFFFFFE.
REQ-030 The bench SHALL apply unsigned 0xFFFFFFFF x 0xFFFFFFFF, check hi=0xFFFFFFFE, lo=0x00000001, then apply signed 0x80000000 x 0x80000000 and check hi=0x40000000, lo=0x00000000.
REQ-031 The bench SHALL pulse start again with different operands mid-RUN and check that it is ignored: the result belongs to the first operands, done appears at N+32, and no second done follows.
REQ-032 The bench SHALL hold start=1 through DONE with new operands 7 x 6 and check that the first result is valid for one cycle, busy rises the next cycle, and the second done gives lo=0x0000002A.
REQ-033 The bench SHALL drive reset=0 asynchronously at RUN counter 10 and check that busy, done, hi and lo read 0 immediately and no done occurs before a new start.
